// File: rtl/pipe_pkg.sv
// Shared constants for the CPU pipeline registers: per-stage bundle widths,
// control bit positions, the bubble control value and the skid FSM encoding.
package pipe_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_PC_W   = 32;

  localparam int FD_DATA_W = 32;
  localparam int FD_CTRL_W = 8;
  localparam int DE_DATA_W = 128;
  localparam int DE_CTRL_W = 8;
  localparam int EM_DATA_W = 72;
  localparam int EM_CTRL_W = 8;
  localparam int MW_DATA_W = 72;
  localparam int MW_CTRL_W = 8;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_SAVEIMM  = 3;
  localparam int CTRL_WRITEPC  = 4;

  // A bubble must never write registers or memory, so every control bit is 0.
  localparam logic [7:0] BUBBLE_CTRL_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stage link carrying the data bundle, control bundle and PC.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 8,
  parameter int PC_W   = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;
  logic [PC_W-1:0]   pc;

  modport master (output valid, output data, output ctrl, output pc, input ready);
  modport slave  (input valid, input data, input ctrl, input pc, output ready);
endinterface

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer and EMPTY/ONE/TWO FSM; tells the stage register when
// to load its main entry from the input or from the skid entry.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int PC_W   = DEF_PC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              out_ready,
  output logic              in_ready,
  output logic              load_main_in,
  output logic              load_main_skid,
  output logic              drain,
  output logic [DATA_W-1:0] skid_data,
  output logic [CTRL_W-1:0] skid_ctrl,
  output logic [PC_W-1:0]   skid_pc
);

  skid_state_t state_q, state_d;
  logic        in_ready_q;
  logic        store_skid;
  logic        in_xfer, out_xfer;

  always_comb begin
    in_xfer        = in_valid && in_ready_q;
    out_xfer       = (state_q != SKID_EMPTY) && out_ready;
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    drain          = 1'b0;
    store_skid     = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (in_xfer) begin
          state_d      = SKID_ONE;
          load_main_in = 1'b1;
        end
      end
      SKID_ONE: begin
        if (in_xfer && !out_xfer) begin
          state_d    = SKID_TWO;
          store_skid = 1'b1;
        end else if (!in_xfer && out_xfer) begin
          state_d = SKID_EMPTY;
          drain   = 1'b1;
        end else if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end
      end
      SKID_TWO: begin
        if (out_xfer) begin
          state_d        = SKID_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    if (flush) begin
      state_d        = SKID_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      drain          = 1'b0;
      store_skid     = 1'b0;
    end
  end

  // in_ready comes straight from a flop so no combinational path reaches upstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SKID_EMPTY;
      in_ready_q <= 1'b1;
      skid_data  <= '0;
      skid_ctrl  <= '0;
      skid_pc    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != SKID_TWO);
      if (store_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
        skid_pc   <= in_pc;
      end
    end
  end

  assign in_ready = in_ready_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready, flush and a bubble
// counter. Define PIPE_SKID_EN to add a skid entry and a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              DATA_W      = DEF_DATA_W,
  parameter int              CTRL_W      = DEF_CTRL_W,
  parameter int              PC_W        = DEF_PC_W,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(BUBBLE_CTRL_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  pipe_stage_reg_if.slave         up,
  pipe_stage_reg_if.master        dn,
  output logic [31:0]             bubble_cnt
);

  logic              main_valid_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [PC_W-1:0]   main_pc_q;
  logic [31:0]       bubble_cnt_q;

  logic              in_ready;
  logic              load_in, load_skid, drain;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [PC_W-1:0]   skid_pc;

`ifdef PIPE_SKID_EN
  pipe_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .PC_W   (PC_W)
  ) u_skid (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (up.valid),
    .in_data        (up.data),
    .in_ctrl        (up.ctrl),
    .in_pc          (up.pc),
    .out_ready      (dn.ready),
    .in_ready       (in_ready),
    .load_main_in   (load_in),
    .load_main_skid (load_skid),
    .drain          (drain),
    .skid_data      (skid_data),
    .skid_ctrl      (skid_ctrl),
    .skid_pc        (skid_pc)
  );
`else
  always_comb begin
    in_ready  = dn.ready || !main_valid_q;
    load_in   = up.valid && in_ready;
    drain     = main_valid_q && dn.ready && !load_in;
    load_skid = 1'b0;
    skid_data = '0;
    skid_ctrl = '0;
    skid_pc   = '0;
  end
`endif

  // Bubbles get BUBBLE_CTRL written into the register; data and PC keep their
  // last values since nothing downstream looks at them without valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= BUBBLE_CTRL;
      main_pc_q    <= '0;
    end else if (flush) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= BUBBLE_CTRL;
    end else if (load_skid) begin
      main_valid_q <= 1'b1;
      main_data_q  <= skid_data;
      main_ctrl_q  <= skid_ctrl;
      main_pc_q    <= skid_pc;
    end else if (load_in) begin
      main_valid_q <= 1'b1;
      main_data_q  <= up.data;
      main_ctrl_q  <= up.ctrl;
      main_pc_q    <= up.pc;
    end else if (drain) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= BUBBLE_CTRL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= '0;
    end else if (!main_valid_q && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign up.ready   = in_ready;
  assign dn.valid   = main_valid_q;
  assign dn.data    = main_data_q;
  assign dn.ctrl    = main_ctrl_q;
  assign dn.pc      = main_pc_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the five-stage CPU.
- Replaces hand-written per-stage registers (F/D, D/E, E/M, M/W) with one block that carries a packed data bundle, a packed control bundle and the stage PC.
- Adds a valid/ready handshake, stall back-pressure and synchronous flush with bubble insertion.
- Hazard unit drives `flush`; the downstream stage drives `out_ready`.

Parameters:
- DATA_W, 128, width of packed datapath bundle (operands, ALU result, immediate, write-register index).
- CTRL_W, 8, width of packed control bundle (RegWrite, MemWrite, MemToReg, ...); forced to BUBBLE_CTRL on bubbles.
- PC_W, 32, width of PC field.
- BUBBLE_CTRL, 0, control value presented whenever the stage holds no valid instruction.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream datapath bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_pc  in  PC_W  upstream PC.
- flush  in  1  kill all held and incoming entries this cycle.
- out_valid  out  1  stage output holds a valid instruction.
- out_ready  in  1  downstream accepts this cycle (0 = stall).
- out_data  out  DATA_W  registered datapath bundle.
- out_ctrl  out  CTRL_W  registered control bundle; BUBBLE_CTRL when out_valid=0.
- out_pc  out  PC_W  registered PC.
- bubble_cnt  out  32  count of cycles with out_valid=0 since reset (perf counter, saturating).

Behaviour:
- Reset: out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, out_pc=0, bubble_cnt=0, all internal entries empty. in_ready=1 in the cycle after reset deasserts.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Latency: 1 cycle from input transfer to out_valid=1 when the stage is empty and not stalled.
- Throughput: 1 per cycle when out_ready is held high.
- Base (no skid):
  - in_ready = out_ready || !out_valid (combinational).
  - On input transfer: out_* <= in_*, out_valid <= 1.
  - On output transfer with no input transfer: out_valid <= 0, out_ctrl <= BUBBLE_CTRL. out_data and out_pc retain their last values.
  - Stall (out_valid=1, out_ready=0): all outputs hold; in_ready=0.
- Flush:
  - Highest priority after reset.
  - Next cycle: out_valid=0, out_ctrl=BUBBLE_CTRL, all internal entries empty.
  - in_ready is still driven by the normal rule during flush. Any same-cycle input transfer is accepted and discarded.
  - out_data and out_pc are not cleared by flush.
- Simultaneous flush and stall: flush wins; the stalled entry is discarded.
- bubble_cnt increments each cycle out_valid=0, saturates at 0xFFFFFFFF, and is not cleared by flush.
- Control gating is registered, never a combinational mask on out_ctrl.

Optional Feature:
- Macro PIPE_SKID_EN adds a one-entry skid buffer so that in_ready is a pure register output (breaks the combinational out_ready->in_ready path).
- States:
  - EMPTY: main and skid empty.
  - ONE: main valid.
  - TWO: main and skid valid.
- Signals: in_ready = (state != TWO), registered. out_* always come from the main entry.
- Transitions:
  - EMPTY: input transfer -> ONE.
  - ONE: input transfer without output transfer -> TWO (input goes to skid); output transfer without input transfer -> EMPTY; both -> ONE (main <= in).
  - TWO: output transfer -> ONE (main <= skid).
  - Any state: flush -> EMPTY.
- Without the macro: base single-register behaviour, and the state is simply out_valid.

Decomposition:
- pipe_pkg holds:
  - per-stage CTRL_W/DATA_W constants;
  - control bit index constants (CTRL_REGWRITE, CTRL_MEMWRITE, CTRL_MEMTOREG, CTRL_SAVEIMM, CTRL_WRITEPC);
  - BUBBLE_CTRL default;
  - skid state encoding typedef.
- One natural sub-module: pipe_skid_buf (skid entry plus EMPTY/ONE/TWO FSM), instantiated only under PIPE_SKID_EN.

Test Plan:
- Reset with in_valid=1, in_ctrl=0xFF -> out_valid=0, out_ctrl=0x00, out_pc=0, bubble_cnt=0 during reset and the cycle after.
- Stream PC 0x3000,0x3004,0x3008 with out_ready=1 -> out_pc shows each value 1 cycle later, back-to-back, out_valid held 1.
- Hold in_pc=0x3010 valid, out_ready=0 for 3 cycles -> out_pc=0x3010 held, in_ready=0 (base); under PIPE_SKID_EN the next PC 0x3014 is accepted into skid, then in_ready=0; release -> 0x3010 then 0x3014, none lost or duplicated.
- flush with out_valid=1 and in_valid=1 in same cycle -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, incoming instruction never appears.
- flush with out_ready=0 and skid full (PIPE_SKID_EN) -> EMPTY next cycle, in_ready=1.
- 10 cycles idle after reset -> bubble_cnt=10; force counter to 0xFFFFFFFE, 3 idle cycles -> 0xFFFFFFFF.
